rr_arbiter4: RTL and testbench
==============================

# rr_arbiter4

Four-requester round-robin arbiter that shares a single downstream resource among request lines `req[3:0]`. It issues a registered one-hot grant plus its 2-bit encoded index, the same 4-to-2 encoding as the team's encoder block, so the index can drive a mux select directly. The grant is held while the owner keeps its request asserted. An optional hold limit forces fairness under contention.

## Interface
- `HOLD_MAX`, default 8: maximum consecutive grant cycles per owner when other requests are pending. Legal range 2..255. Used only with `ARB_TIMEOUT_EN`.
- `clk`  input  1  single clock; all logic on the rising edge.
- `rst`  input  1  synchronous, active-high reset, sampled on the `clk` rising edge.
- `req`  input  4  request lines; bit i is requester i, level-sensitive.
- `gnt`  output  4  one-hot grant, registered; all zero when idle.
- `gnt_idx`  output  2  binary index of the set `gnt` bit. 0 when `gnt_valid`=0.
- `gnt_valid`  output  1  high while a grant is active; equals `|gnt`.

## Operation
- Internal state:
  - FSM with states IDLE and GRANT.
  - `ptr[1:0]`: index of the last granted requester.
  - `hold_cnt[7:0]`: saturating cycle counter for the current grant.
- Winner selection: the first set bit of `req` found searching `ptr+1, ptr+2, ptr+3, ptr` (mod 4, wraps 3→0).
- IDLE:
  - If `req`≠0: grant the winner; set `ptr`←winner, `hold_cnt`←0; go to GRANT.
  - Otherwise stay in IDLE with outputs zero.
- GRANT, owner `o` = `gnt_idx`:
  - **Release.** If `req[o]`=0 and other requests are pending, grant the next winner at the same edge (back-to-back, no gap). Set `ptr`←winner and `hold_cnt`←0.
  - **Release, no other requests.** If `req[o]`=0 and `req`=0: `gnt`←0, `gnt_idx`←0, go to IDLE. `ptr` keeps `o`.
  - **Hold.** If `req[o]`=1: keep the grant and increment `hold_cnt`, saturating at 255.
  - **Preempt** (only with `ARB_TIMEOUT_EN`). If `req[o]`=1, `hold_cnt`=`HOLD_MAX`−1, and any other `req` bit is set: grant the next winner, skipping `o`. Set `ptr`←winner and `hold_cnt`←0.
  - With preemption, `o` must re-compete; it is served again only after every other pending requester.
- Invariants, every cycle:
  - `gnt` is zero or one-hot.
  - `gnt_idx` equals the encoding of `gnt`.
  - `gnt_valid` = `|gnt`.
  - Never grant a requester whose `req` bit was 0 at the deciding edge.
- Simultaneous events:
  - If release and a new request arrive in the same cycle, the new request takes part in that edge's selection.
  - If release and timeout coincide, treat it as a release; `hold_cnt` is irrelevant.

## Timing
- Reset values: `gnt`=4'b0000, `gnt_idx`=2'b00, `gnt_valid`=0, state IDLE, `ptr`=3 (the first search starts at requester 0), `hold_cnt`=0.
- Reset mid-grant: outputs are zero in the cycle after the `rst` edge; any pending grant is dropped; `ptr` returns to 3.
- Grant latency: `req` sampled at edge N → `gnt` valid after edge N (visible in cycle N+1).
- Release latency: `req[o]` low at edge N → `gnt[o]` low after edge N. Any new grant appears in the same cycle.
- Hold limit: with contention, an owner holds at most `HOLD_MAX` consecutive cycles.
- No combinational path from `req` to any output.

## Configuration
- Macro `ARB_TIMEOUT_EN`.
- Defined: the hold counter and the preemption rule are compiled in; `HOLD_MAX` is active.
- Undefined:
  - No preemption; the owner holds the grant for as long as `req[o]`=1.
  - `hold_cnt` logic is removed; `HOLD_MAX` is ignored.
  - All other behaviour is identical.

## Test plan
- **Reset and idle.** Assert `rst` for 2 cycles with `req`=4'b1111, then release → cycle after release: `gnt`=4'b0001, `gnt_idx`=0. While `rst`=1: all outputs 0.
- **Round-robin rotation.** Hold `req`=4'b1111, each owner dropping its bit for 1 cycle after 3 grant cycles → grant order 0,1,2,3,0 with no idle gap, and `gnt_idx` tracking 0,1,2,3,0.
- **Single requester and wrap.**
  - `ptr`=2, `req`=4'b0001 → `gnt`=4'b0001.
  - Then drop `req` → IDLE, `gnt_valid`=0 the next cycle.
  - Then `req`=4'b0011 → `gnt`=4'b0010.
- **Preemption** (`ARB_TIMEOUT_EN`, `HOLD_MAX`=4). Requester 2 holds `req` high; requester 0 requests at cycle 1 → `gnt`=4'b0100 for exactly 4 cycles, then 4'b0001. Without the macro: 4'b0100 persists for 20 cycles.
- **Release with no contention.** Owner 1 drops `req` with all other bits 0 → next cycle `gnt`=0, `gnt_idx`=0. Then `req`=4'b0010 again → requester 1 is granted after a 1-cycle latency.
- **Reset mid-grant and invariants.** Pulse `rst` while `gnt`=4'b1000 → outputs 0 the next cycle; `req`=4'b1001 then grants requester 0. Throughout a 1000-cycle random run, check one-hot `gnt`, the `gnt_idx` encoding, and no grant without a request.

Source files
------------

// File: rtl/rr_arbiter4.sv
// rr_arbiter4 -- four-requester round-robin arbiter with registered grant.
//
// Purpose:
//   Shares one downstream resource among req[3:0]. The current owner keeps
//   the grant while its request stays high. Handover to the next requester
//   is back-to-back, with no idle cycle. The search for the next owner starts
//   just after the last granted index.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   When the macro is defined, an owner that holds the grant for HOLD_MAX
//   consecutive cycles while others are waiting is preempted. When it is
//   undefined, the hold counter is not built and HOLD_MAX has no effect.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous active-high reset
//   req        in   4  level-sensitive request lines, bit i = requester i
//   gnt        out  4  registered one-hot grant, zero when idle
//   gnt_idx    out  2  binary index of the set gnt bit, zero when idle
//   gnt_valid  out  1  |gnt
module rr_arbiter4 #(
    parameter int unsigned HOLD_MAX = 8   // legal 2..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] gnt_idx_q, gnt_idx_d;

    logic       preempt;
    logic       others;
    logic       win_found;
    logic [1:0] win_idx;

    // Rotating priority search. Candidates are visited in the order
    // p+1, p+2, p+3, p (mod 4). When skip_p is set, the last candidate is
    // dropped so that a preempted owner cannot win its own slot back.
    function automatic logic [2:0] rr_pick(input logic [3:0] r,
                                           input logic [1:0] p,
                                           input logic       skip_p);
        logic       found;
        logic [1:0] idx;
        logic [1:0] w;
        found = 1'b0;
        w     = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx] && !(k == 4 && skip_p)) begin
                found = 1'b1;
                w     = idx;
            end
        end
        return {found, w};
    endfunction

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] hold_cnt_q, hold_cnt_d;
`else
    logic unused_hold_max;
    assign unused_hold_max = ^8'(HOLD_MAX);
`endif

    // Some requester other than the current owner is waiting. When idle,
    // gnt_q is zero, so this is simply |req.
    assign others = |(req & ~gnt_q);

    always_comb begin
        preempt = 1'b0;
`ifdef ARB_TIMEOUT_EN
        // If release and timeout coincide, the release branch wins, because
        // req[owner] must still be high here.
        preempt = (state_q == GRANT) && req[gnt_idx_q] &&
                  (hold_cnt_q == HOLD_LAST) && others;
`endif
        {win_found, win_idx} = rr_pick(req, ptr_q, preempt);
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
`endif
        if (state_q == IDLE || !req[gnt_idx_q] || preempt) begin
            if (win_found) begin
                state_d   = GRANT;
                ptr_d     = win_idx;
                gnt_d     = 4'b0001 << win_idx;
                gnt_idx_d = win_idx;
`ifdef ARB_TIMEOUT_EN
                hold_cnt_d = 8'd0;
`endif
            end else begin
                // Nothing to hand over to. ptr keeps the last owner.
                state_d   = IDLE;
                gnt_d     = 4'b0000;
                gnt_idx_d = 2'd0;
            end
        end else begin
`ifdef ARB_TIMEOUT_EN
            if (hold_cnt_q != 8'hFF) begin
                hold_cnt_d = hold_cnt_q + 8'd1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd3;
            gnt_q     <= 4'b0000;
            gnt_idx_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= 8'd0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`endif

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = |gnt_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4. Directed scenarios run first, then
// a randomized run. Outputs are compared every cycle against a behavioural
// model that tracks the owner number, the last-served index and the number
// of cycles the owner has held the grant.
module tb_rr_arbiter4;

    localparam int HM = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;

    int n_tests;
    int n_fail;

    rr_arbiter4 #(.HOLD_MAX(HM)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_owner;    // -1 when nobody holds the grant
    int         m_last;     // last served requester
    int         m_held;     // cycles the owner has held the grant, minus one
    logic [3:0] m_req_seen;
    bit         m_on;

    // Round robin: walk forward from the last served requester. A preempted
    // owner is excluded from the walk.
    function automatic int next_owner(input logic [3:0] r, input int last, input bit excl);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (last + k) % 4;
            if (r[c] && !(excl && c == last)) return c;
        end
        return -1;
    endfunction

    initial begin
        m_owner = -1; m_last = 3; m_held = 0; m_on = 1'b0; m_req_seen = '0;
    end

    always @(posedge clk) begin
        int w;
        int busy;
        m_on       = 1'b1;
        m_req_seen = req;
        if (rst) begin
            m_owner = -1; m_last = 3; m_held = 0;
        end else if (m_owner < 0 || !req[m_owner]) begin
            w = next_owner(req, m_last, 1'b0);
            m_owner = w;
            if (w >= 0) begin m_last = w; m_held = 0; end
        end else begin
            busy = 0;
            for (int i = 0; i < 4; i++) if (i != m_owner && req[i]) busy = 1;
`ifdef ARB_TIMEOUT_EN
            if (busy == 1 && m_held + 1 >= HM) begin
                w = next_owner(req, m_last, 1'b1);
                m_owner = w; m_last = w; m_held = 0;
            end else if (m_held < 255) begin
                m_held++;
            end
`else
            if (busy == 1 && m_held < 255) m_held++;
            else if (m_held < 255) m_held++;
`endif
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("gnt",   32'(gnt),       (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
            chk("idx",   32'(gnt_idx),   (m_owner < 0) ? 32'd0 : 32'(m_owner));
            chk("valid", 32'(gnt_valid), (m_owner < 0) ? 32'd0 : 32'd1);
            chk("onehot", 32'($countones(gnt) <= 1), 32'd1);
            chk("no_req_gnt", 32'(gnt & ~m_req_seen), 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0000;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        req = 4'b1111;

        // Reset and idle: outputs stay zero while rst is high.
        cyc(); cyc();
        chk("rst_gnt",   32'(gnt),       32'd0);
        chk("rst_valid", 32'(gnt_valid), 32'd0);
        rst = 1'b0;
        cyc();
        chk("post_rst_gnt", 32'(gnt),     32'h1);
        chk("post_rst_idx", 32'(gnt_idx), 32'd0);

        // Rotation 0,1,2,3,0 with each owner dropping its bit in turn.
        for (int k = 0; k < 5; k++) begin
            chk("rot_gnt", 32'(gnt),     32'd1 << (k % 4));
            chk("rot_idx", 32'(gnt_idx), 32'(k % 4));
            cyc(); cyc();
            req = 4'b1111 & ~(4'b0001 << (k % 4));
            cyc();
            req = 4'b1111;
        end

        // Single requester and wrap from ptr=2.
        do_reset();
        req = 4'b0100; cyc(); chk("wrap_g2", 32'(gnt), 32'h4);
        req = 4'b0000; cyc(); chk("wrap_idle", 32'(gnt_valid), 32'd0);
        req = 4'b0001; cyc(); chk("wrap_g0", 32'(gnt), 32'h1);
        req = 4'b0000; cyc(); chk("wrap_idle2", 32'(gnt_valid), 32'd0);
        req = 4'b0011; cyc(); chk("wrap_g1", 32'(gnt), 32'h2);

        // Preemption: requester 2 holds, requester 0 joins a cycle later.
        do_reset();
        req = 4'b0100; cyc();
        chk("pre_first", 32'(gnt), 32'h4);
        req = 4'b0101;
`ifdef ARB_TIMEOUT_EN
        for (int i = 1; i < HM; i++) begin
            cyc(); chk("pre_hold", 32'(gnt), 32'h4);
        end
        cyc(); chk("pre_switch", 32'(gnt), 32'h1);
`else
        for (int i = 1; i < 20; i++) begin
            cyc(); chk("nopre_hold", 32'(gnt), 32'h4);
        end
`endif

        // Release with no contention, then re-request.
        do_reset();
        req = 4'b0010; cyc(); chk("rel_g1", 32'(gnt), 32'h2);
        req = 4'b0000; cyc();
        chk("rel_gnt0", 32'(gnt),     32'd0);
        chk("rel_idx0", 32'(gnt_idx), 32'd0);
        req = 4'b0010; cyc(); chk("rel_regnt", 32'(gnt), 32'h2);

        // Reset mid-grant.
        do_reset();
        req = 4'b1000; cyc(); chk("mid_g3", 32'(gnt), 32'h8);
        rst = 1'b1; cyc();
        chk("mid_rst", 32'(gnt), 32'd0);
        rst = 1'b0; req = 4'b1001; cyc();
        chk("mid_g0", 32'(gnt), 32'h1);

        // Random run. Requests are sticky so that long holds and
        // preemptions show up, with an occasional reset pulse.
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 99) < 30) req = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 99) < 2);
            cyc();
        end
        rst = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
